// File: rtl/gpmc_initiator_pkg.sv
// rtl/gpmc_initiator_pkg.sv - shared GPMC state encodings, control vectors and AD width
package gpmc_initiator_pkg;

  localparam int AD_WIDTH  = 16;
  localparam int CNT_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_TURN  = 3'd4
  } gpmc_state_e;

  // Active-low strobes in bus order {csn, advn, wein, oen}
  typedef struct packed {
    logic csn;
    logic advn;
    logic wein;
    logic oen;
  } gpmc_ctrl_t;

  localparam gpmc_ctrl_t CTRL_IDLE  = 4'b1111;
  localparam gpmc_ctrl_t CTRL_ADDR  = 4'b0011;
  localparam gpmc_ctrl_t CTRL_WRITE = 4'b0101;
  localparam gpmc_ctrl_t CTRL_READ  = 4'b0110;

  function automatic gpmc_ctrl_t ctrl_for_state(input gpmc_state_e st);
    case (st)
      ST_ADDR:  return CTRL_ADDR;
      ST_WRITE: return CTRL_WRITE;
      ST_READ:  return CTRL_READ;
      default:  return CTRL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/gpmc_initiator_phase_timer.sv
// rtl/gpmc_initiator_phase_timer.sv - bus-period counter for the GPMC initiator phases
// done marks the last clk of the final period (gpmc_clk high, about to fall).
module gpmc_initiator_phase_timer
  import gpmc_initiator_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 tick,
  output logic                 done
);

  logic [CNT_WIDTH-1:0] count;

  assign done = tick && (count == CNT_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && !done) begin
      count <= count - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/gpmc_initiator.sv
// rtl/gpmc_initiator.sv - multiplexed-AD GPMC bus initiator for bridge self-test and loopback
// The FSM state leads the bus by one clk; strobes and AD are launched only on gpmc_clk rises.
module gpmc_initiator
  import gpmc_initiator_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int ADDR_CYCLES = 1,
  parameter int WR_CYCLES   = 1,
  parameter int RD_WAIT     = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [AD_WIDTH-1:0]   req_wdata,
  output logic                  rsp_valid,
  output logic [AD_WIDTH-1:0]   rsp_rdata,
  output logic                  busy,
  output logic                  gpmc_clk,
  output logic                  gpmc_csn1,
  output logic                  gpmc_advn,
  output logic                  gpmc_wein,
  output logic                  gpmc_oen,
  output logic [AD_WIDTH-1:0]   gpmc_ad_out,
  output logic                  gpmc_ad_oe,
  input  logic [AD_WIDTH-1:0]   gpmc_ad_in
);

  gpmc_state_e           state;
  gpmc_state_e           state_next;
  logic                  ready_en;
  logic                  accept;
  logic                  rise;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [AD_WIDTH-1:0]   wdata_q;
  logic [AD_WIDTH-1:0]   addr_ext;
  logic                  tmr_load;
  logic [CNT_WIDTH-1:0]  tmr_val;
  logic                  tmr_done;
  logic                  sample_pend;
  gpmc_ctrl_t            ctrl_d;
  logic                  ad_oe_d;
  logic [AD_WIDTH-1:0]   ad_out_d;

  // ready_en keeps req_ready low for the whole of reset, rising on the first clk after release
  assign req_ready = ready_en && (state == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign busy      = (state != ST_IDLE);
  assign rise      = busy && !gpmc_clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:           if (accept)   state_next = ST_ADDR;
      ST_ADDR:           if (tmr_done) state_next = we_q ? ST_WRITE : ST_READ;
      ST_WRITE, ST_READ: if (tmr_done) state_next = ST_TURN;
      ST_TURN:           if (tmr_done) state_next = ST_IDLE;
      default:                         state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl_d   = ctrl_for_state(state);
    ad_oe_d  = 1'b0;
    ad_out_d = '0;
    case (state)
      ST_ADDR: begin
        ad_oe_d  = 1'b1;
        ad_out_d = addr_ext;
      end
      ST_WRITE: begin
        ad_oe_d  = 1'b1;
        ad_out_d = wdata_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    addr_ext                   = '0;
    addr_ext[ADDR_WIDTH-1:0]   = addr_q;
  end

  assign tmr_load = (state_next != state);

  always_comb begin
    tmr_val = CNT_WIDTH'(ADDR_CYCLES);
    case (state_next)
      ST_WRITE: tmr_val = CNT_WIDTH'(WR_CYCLES);
      ST_READ:  tmr_val = CNT_WIDTH'(RD_WAIT);
      ST_TURN:  tmr_val = CNT_WIDTH'(TURN_CYCLES);
      default:  tmr_val = CNT_WIDTH'(ADDR_CYCLES);
    endcase
  end

  gpmc_initiator_phase_timer u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (gpmc_clk),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      gpmc_clk <= 1'b0;
    else if (state_next == ST_IDLE)  gpmc_clk <= 1'b0;
    else if (busy)                   gpmc_clk <= ~gpmc_clk;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {gpmc_csn1, gpmc_advn, gpmc_wein, gpmc_oen} <= CTRL_IDLE;
      gpmc_ad_oe  <= 1'b0;
      gpmc_ad_out <= '0;
    end else if (rise) begin
      {gpmc_csn1, gpmc_advn, gpmc_wein, gpmc_oen} <= ctrl_d;
      gpmc_ad_oe  <= ad_oe_d;
      gpmc_ad_out <= ad_out_d;
    end
  end

  // READ->TURN happens mid-period; the sample lands on the following rise, which ends the last wait period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_pend <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      sample_pend <= (state == ST_READ) && (state_next == ST_TURN);
      rsp_valid   <= sample_pend;
      if (sample_pend) rsp_rdata <= gpmc_ad_in;
    end
  end

endmodule
